// File: rtl/mips_cpu_mem_arbiter.sv
// Avalon-MM master arbiter for mips_cpu_bus: round-robin between instruction fetch
// and load/store, holds the bus across waitrequest stalls, and runs a stall watchdog.
module mips_cpu_mem_arbiter #(
  parameter int unsigned WAIT_LIMIT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_done,
  input  logic        d_req,
  input  logic        d_write,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_be,
  output logic [31:0] d_rdata,
  output logic        d_done,
  output logic [31:0] mem_address,
  output logic        memread,
  output logic        memwrite,
  output logic [31:0] memwritedata,
  output logic [3:0]  byteenable,
  input  logic        waitrequest,
  input  logic [31:0] memreaddata,
  output logic        busy,
  output logic        stall_err
);

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_t;

  state_t      r_state;
  logic        r_grant_d;
  logic        r_last_d;
  logic [15:0] r_wcnt;

  logic        w_any;
  logic        w_grant_d;
  logic [16:0] w_wcnt_inc;

  // On a tie the port that did not win last time gets the bus.
  assign w_any      = if_req | d_req;
  assign w_grant_d  = (if_req && d_req) ? !r_last_d : d_req;
  assign w_wcnt_inc = {1'b0, r_wcnt} + 17'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_grant_d    <= 1'b0;
      r_last_d     <= 1'b1;
      r_wcnt       <= '0;
      mem_address  <= '0;
      memread      <= 1'b0;
      memwrite     <= 1'b0;
      memwritedata <= '0;
      byteenable   <= '0;
      if_rdata     <= '0;
      d_rdata      <= '0;
      if_done      <= 1'b0;
      d_done       <= 1'b0;
      busy         <= 1'b0;
      stall_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_grant_d <= w_grant_d;
            r_last_d  <= w_grant_d;
            r_wcnt    <= '0;
            busy      <= 1'b1;
            r_state   <= S_BUS;
            if (w_grant_d) begin
              mem_address  <= d_addr;
              memread      <= !d_write;
              memwrite     <= d_write;
              memwritedata <= d_wdata;
              byteenable   <= d_be;
            end else begin
              mem_address <= if_addr;
              memread     <= 1'b1;
              memwrite    <= 1'b0;
              byteenable  <= '1;
            end
          end
        end
        S_BUS: begin
          if (waitrequest) begin
            // Watchdog only flags; the transfer keeps waiting on the slave.
            if (r_wcnt != '1) r_wcnt <= w_wcnt_inc[15:0];
            if (32'(w_wcnt_inc) >= WAIT_LIMIT) stall_err <= 1'b1;
          end else begin
            if (memread) begin
              if (r_grant_d) d_rdata  <= memreaddata;
              else           if_rdata <= memreaddata;
            end
            memread  <= 1'b0;
            memwrite <= 1'b0;
            if_done  <= !r_grant_d;
            d_done   <= r_grant_d;
            r_state  <= S_RESP;
          end
        end
        S_RESP: begin
          if_done <= 1'b0;
          d_done  <= 1'b0;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_cpu_mem_arbiter.sv
// Directed bench for mips_cpu_mem_arbiter: single fetch, stalled write, load return,
// round-robin ties, watchdog at WAIT_LIMIT=4, and reset during a stalled transfer.
module tb_mips_cpu_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_done;
  logic        d_req;
  logic        d_write;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_be;
  logic [31:0] d_rdata;
  logic        d_done;
  logic [31:0] mem_address;
  logic        memread;
  logic        memwrite;
  logic [31:0] memwritedata;
  logic [3:0]  byteenable;
  logic        waitrequest;
  logic [31:0] memreaddata;
  logic        busy;
  logic        stall_err;

  int n_assert = 0;
  int n_fail   = 0;

  mips_cpu_mem_arbiter #(.WAIT_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .d_req(d_req), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_rdata(d_rdata), .d_done(d_done),
    .mem_address(mem_address), .memread(memread), .memwrite(memwrite),
    .memwritedata(memwritedata), .byteenable(byteenable),
    .waitrequest(waitrequest), .memreaddata(memreaddata),
    .busy(busy), .stall_err(stall_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      $error("check %s wrong", tag);
    end
  endtask

  initial begin
    reset = 1'b1; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_write = 1'b0;
    d_addr = '0; d_wdata = '0; d_be = '0; waitrequest = 1'b0; memreaddata = '0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_memread",  32'(memread), 32'd0);
    chk("rst_memwrite", 32'(memwrite), 32'd0);
    chk("rst_addr",     mem_address, 32'd0);
    chk("rst_wdata",    memwritedata, 32'd0);
    chk("rst_be",       32'(byteenable), 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_d_rdata",  d_rdata, 32'd0);
    chk("rst_dones",    32'({if_done, d_done}), 32'd0);
    chk("rst_busy",     32'(busy), 32'd0);
    chk("rst_stall",    32'(stall_err), 32'd0);

    // Single fetch, no wait states
    if_req = 1'b1; if_addr = 32'hBFC00000; memreaddata = 32'h8C020004;
    tick();
    chk("f1_memread",  32'(memread), 32'd1);
    chk("f1_memwrite", 32'(memwrite), 32'd0);
    chk("f1_addr",     mem_address, 32'hBFC00000);
    chk("f1_be",       32'(byteenable), 32'hF);
    chk("f1_busy",     32'(busy), 32'd1);
    chk("f1_done_early", 32'(if_done), 32'd0);
    tick();
    chk("f1_if_done",  32'(if_done), 32'd1);
    chk("f1_if_rdata", if_rdata, 32'h8C020004);
    chk("f1_d_done",   32'(d_done), 32'd0);
    chk("f1_strobe_drop", 32'(memread), 32'd0);
    if_req = 1'b0;
    tick();
    chk("f1_done_clear", 32'(if_done), 32'd0);
    chk("f1_idle_busy",  32'(busy), 32'd0);

    // Data write with 3 stall cycles; requester fields change after the grant
    d_req = 1'b1; d_write = 1'b1; d_addr = 32'h1000; d_wdata = 32'hDEADBEEF; d_be = 4'b0011;
    waitrequest = 1'b1; memreaddata = 32'h55555555;
    tick();
    d_wdata = 32'h0; d_be = 4'b1100;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) waitrequest = 1'b0;
      chk("w_memwrite", 32'(memwrite), 32'd1);
      chk("w_memread",  32'(memread), 32'd0);
      chk("w_addr",     mem_address, 32'h1000);
      chk("w_wdata",    memwritedata, 32'hDEADBEEF);
      chk("w_be",       32'(byteenable), 32'h3);
      chk("w_no_done",  32'({if_done, d_done}), 32'd0);
      tick();
    end
    chk("w_d_done",   32'(d_done), 32'd1);
    chk("w_if_done",  32'(if_done), 32'd0);
    chk("w_strobe",   32'(memwrite), 32'd0);
    chk("w_d_rdata",  d_rdata, 32'd0);
    chk("w_stall_3",  32'(stall_err), 32'd0);
    d_req = 1'b0;
    tick();
    chk("w_done_clear", 32'(d_done), 32'd0);

    // Load from 0x2000
    d_req = 1'b1; d_write = 1'b0; d_addr = 32'h2000; d_be = 4'b1111; memreaddata = 32'h12345678;
    tick();
    chk("ld_memread",  32'(memread), 32'd1);
    chk("ld_memwrite", 32'(memwrite), 32'd0);
    chk("ld_addr",     mem_address, 32'h2000);
    tick();
    chk("ld_d_done",   32'(d_done), 32'd1);
    chk("ld_d_rdata",  d_rdata, 32'h12345678);
    chk("ld_if_rdata", if_rdata, 32'h8C020004);
    d_req = 1'b0; memreaddata = 32'h0;
    tick();
    chk("ld_done_low", 32'(d_done), 32'd0);
    chk("ld_hold",     d_rdata, 32'h12345678);

    // Both requests held after reset: fetch, data, fetch, data
    reset = 1'b1;
    tick();
    reset = 1'b0;
    if_req = 1'b1; if_addr = 32'h000000A0; d_req = 1'b1; d_write = 1'b0; d_addr = 32'h000000D0;
    for (int i = 0; i < 4; i++) begin
      memreaddata = 32'h1000 + 32'(i);
      tick();
      chk("rr_addr",    mem_address, (i % 2 == 0) ? 32'hA0 : 32'hD0);
      chk("rr_memread", 32'(memread), 32'd1);
      tick();
      chk("rr_if_done", 32'(if_done), (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("rr_d_done",  32'(d_done),  (i % 2 == 0) ? 32'd0 : 32'd1);
      if (i % 2 == 0) chk("rr_if_rdata", if_rdata, 32'h1000 + 32'(i));
      else            chk("rr_d_rdata",  d_rdata,  32'h1000 + 32'(i));
      tick();
      chk("rr_gap", 32'({if_done, d_done}), 32'd0);
    end
    if_req = 1'b0; d_req = 1'b0;
    tick(); tick(); tick();

    // Watchdog with WAIT_LIMIT=4
    if_req = 1'b1; if_addr = 32'h00400000; waitrequest = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("wd_pre", 32'(stall_err), 32'd0);
      chk("wd_memread", 32'(memread), 32'd1);
      tick();
    end
    chk("wd_set",     32'(stall_err), 32'd1);
    chk("wd_memread_held", 32'(memread), 32'd1);
    chk("wd_no_done", 32'(if_done), 32'd0);
    waitrequest = 1'b0; memreaddata = 32'hCAFEF00D;
    tick();
    chk("wd_if_done",  32'(if_done), 32'd1);
    chk("wd_if_rdata", if_rdata, 32'hCAFEF00D);
    chk("wd_sticky",   32'(stall_err), 32'd1);
    if_req = 1'b0;
    tick();
    chk("wd_sticky_idle", 32'(stall_err), 32'd1);

    // Reset while a fetch is stalled in BUS
    if_req = 1'b1; if_addr = 32'h00000300; waitrequest = 1'b1;
    tick();
    chk("rb_memread", 32'(memread), 32'd1);
    reset = 1'b1;
    tick();
    chk("rb_memread0",  32'(memread), 32'd0);
    chk("rb_memwrite0", 32'(memwrite), 32'd0);
    chk("rb_busy",      32'(busy), 32'd0);
    chk("rb_dones",     32'({if_done, d_done}), 32'd0);
    chk("rb_stall",     32'(stall_err), 32'd0);
    reset = 1'b0; waitrequest = 1'b0;
    d_req = 1'b1; d_write = 1'b0; d_addr = 32'h00000400; memreaddata = 32'h0BADF00D;
    tick();
    chk("rb_tie_addr", mem_address, 32'h00000300);
    tick();
    chk("rb_tie_if_done", 32'(if_done), 32'd1);
    chk("rb_tie_d_done",  32'(d_done), 32'd0);
    if_req = 1'b0; d_req = 1'b0;
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
